uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning byte width per frame.
REQ-003 SHALL have parameter START_TMO, default 4, meaning cycles allowed in WAIT_START for TX_BUSY to rise.
REQ-004 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port REQ_VALID  input  NUM_REQ  per-requester byte available.
REQ-007 SHALL have port REQ_DATA  input  NUM_REQ*DATA_WIDTH  flattened bytes, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port REQ_MASK  input  NUM_REQ  per-requester enable; 0 excludes requester from arbitration.
REQ-009 SHALL have port REQ_READY  output  NUM_REQ  one-hot accept strobe.
REQ-010 SHALL have port TX_BUSY  input  1  registered busy from UART transmitter.
REQ-011 SHALL have port TX_DATA_VALID  output  1  one-cycle frame start strobe to transmitter.
REQ-012 SHALL have port TX_P_DATA  output  DATA_WIDTH  byte to transmitter.
REQ-013 SHALL have port GNT_ID  output  clog2(NUM_REQ)  index of the requester owning the current frame.
REQ-014 SHALL have port ACTIVE  output  1  high in every state except IDLE.
REQ-015 SHALL have port FRAME_DONE  output  1  one-cycle pulse when a frame completes.
REQ-016 SHALL have port START_ERR  output  1  one-cycle pulse when the transmitter fails to go busy.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-018 IDLE: eligible = REQ_VALID & REQ_MASK; if eligible != 0 and TX_BUSY = 0, SHALL select winner round-robin, drive REQ_READY[winner] = 1 combinationally that cycle, register REQ_DATA[winner] into TX_P_DATA and winner into GNT_ID, and go to ISSUE.
REQ-019 IDLE with TX_BUSY = 1 SHALL accept nothing and stay in IDLE.
REQ-020 Round-robin SHALL search upward from pointer PTR with wrap-around; PTR SHALL load (winner+1) mod NUM_REQ on each accept only.
REQ-021 ISSUE: TX_DATA_VALID SHALL be 1 for exactly this one cycle (decoded from state); next state WAIT_START; timeout counter cleared.
REQ-022 WAIT_START: TX_BUSY = 1 SHALL go to WAIT_DONE; otherwise counter increments, and when it reaches START_TMO the block SHALL pulse START_ERR next cycle and return to IDLE.
REQ-023 WAIT_DONE: TX_BUSY = 0 SHALL return to IDLE and pulse FRAME_DONE in the following cycle.
REQ-024 TX_P_DATA and GNT_ID SHALL hold stable from accept until the next accept.
REQ-025 REQ_READY SHALL be 0 in all states but IDLE; at most one bit set.
REQ-026 Requester dropping REQ_VALID or being masked after accept SHALL NOT affect the frame in flight.
REQ-027 Best-case throughput: accept-to-accept = 3 + frame busy cycles + 1 cycles.

Reset
REQ-028 RST low SHALL asynchronously force state IDLE, PTR 0, counter 0, TX_P_DATA 0, GNT_ID 0, TX_DATA_VALID 0, REQ_READY 0, ACTIVE 0, FRAME_DONE 0, START_ERR 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no FRAME_DONE or START_ERR pulse; first accept after release SHALL begin the search at requester 0.

Structure
REQ-030 State encodings and default START_TMO SHALL live in shared package uart_pkg alongside the existing transmitter state constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs eligible, PTR; outputs one-hot grant, index, any).

Verification
REQ-032 Single req: REQ_VALID=0001, REQ_DATA[0]=0xA5, TX model busy 2 cycles after strobe for 11 cycles -> REQ_READY=0001 once, TX_P_DATA=0xA5, GNT_ID=0, one TX_DATA_VALID, FRAME_DONE once.
REQ-033 All four valid continuously, data 0x10/0x11/0x12/0x13 -> grant order 0,1,2,3,0 and TX_P_DATA follows.
REQ-034 REQ_MASK=1011 with all valid -> requester 2 never granted; order 0,1,3,0.
REQ-035 TX model never asserts busy -> START_ERR pulses 5 cycles after TX_DATA_VALID, state IDLE, next request re-accepted.
REQ-036 RST low during WAIT_DONE -> all outputs 0 immediately, no FRAME_DONE; after release with REQ_VALID=1100 the grant goes to requester 2.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants for the transmitter and its frame scheduler.
//   Transmitter state encodings (TX_*), scheduler state encodings (S_*),
//   the default start-timeout and a helper that sizes the timeout counter.
package uart_pkg;
    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_ISSUE      = 2'd1;
    localparam logic [1:0] S_WAIT_START = 2'd2;
    localparam logic [1:0] S_WAIT_DONE  = 2'd3;

    localparam int START_TMO_DEF = 4;

    function automatic int cnt_width(input int tmo);
        return $clog2(tmo + 1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among eligible requesters, searching upward from ptr.
//   eligible : per-requester request vector
//   ptr      : index the search starts at (wraps around)
//   grant    : one-hot winner, idx : winner index, any : some requester eligible
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] j;

    // Walk offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (eligible[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

    assign any = |eligible;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding bytes from NUM_REQ requesters to one UART transmitter.
//   CLK, RST (async, active-low)
//   REQ_VALID/REQ_DATA/REQ_MASK in, REQ_READY out : requester handshake
//   TX_BUSY in, TX_DATA_VALID/TX_P_DATA out       : transmitter handshake
//   GNT_ID, ACTIVE, FRAME_DONE, START_ERR out     : status
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int START_TMO  = START_TMO_DEF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_MASK,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          TX_BUSY,
    output logic                          TX_DATA_VALID,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic [$clog2(NUM_REQ)-1:0]    GNT_ID,
    output logic                          ACTIVE,
    output logic                          FRAME_DONE,
    output logic                          START_ERR
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(START_TMO);

    logic [1:0]         state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_any;
    logic               accept;
    logic [CW-1:0]      cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .eligible(REQ_VALID & REQ_MASK),
        .ptr     (ptr),
        .grant   (win_oh),
        .idx     (win_idx),
        .any     (win_any)
    );

    // RST gates the strobe so REQ_READY is low for the whole reset, not just after an edge.
    assign accept        = RST && state == S_IDLE && !TX_BUSY && win_any;
    assign REQ_READY     = accept ? win_oh : '0;
    assign TX_DATA_VALID = state == S_ISSUE;
    assign ACTIVE        = state != S_IDLE;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            TX_P_DATA  <= '0;
            GNT_ID     <= '0;
            FRAME_DONE <= 1'b0;
            START_ERR  <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            START_ERR  <= 1'b0;
            if (accept) begin
                state     <= S_ISSUE;
                TX_P_DATA <= REQ_DATA[win_idx*DATA_WIDTH +: DATA_WIDTH];
                GNT_ID    <= win_idx;
                ptr       <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            if (state == S_ISSUE) begin
                state <= S_WAIT_START;
                cnt   <= '0;
            end
            if (state == S_WAIT_START) begin
                cnt <= cnt + 1'b1;
                if (TX_BUSY) begin
                    state <= S_WAIT_DONE;
                end else if (cnt == CW'(START_TMO - 1)) begin
                    state     <= S_IDLE;
                    START_ERR <= 1'b1;
                end
            end
            if (state == S_WAIT_DONE && !TX_BUSY) begin
                state      <= S_IDLE;
                FRAME_DONE <= 1'b1;
            end
        end
    end
endmodule
